// File: rtl/register_tree_driver.sv
// Host-side command sequencer for the register-tree priority queue: turns push/pop
// handshakes into spaced write/read/replace strobes and returns popped maxima.
module register_tree_driver #(
   parameter int DATA_WIDTH    = 16,
   parameter int QUEUE_SIZE    = 15,
   parameter int SETTLE_CYCLES = 2 * $clog2(QUEUE_SIZE)
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_push_valid,
   output logic                  o_push_ready,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop_valid,
   output logic                  o_pop_ready,
   output logic                  o_res_valid,
   input  logic                  i_res_ready,
   output logic [DATA_WIDTH-1:0] o_res_data,
   output logic                  o_res_empty,
   output logic                  o_err_zero,
   output logic                  o_q_wrt,
   output logic                  o_q_read,
   output logic [DATA_WIDTH-1:0] o_q_data,
   input  logic                  i_q_full,
   input  logic                  i_q_empty,
   input  logic [DATA_WIDTH-1:0] i_q_data
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, CMD, SETTLE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] settle_cnt;

   logic push_acc;
   logic pop_acc;
   logic key_zero;
   logic do_wrt;
   logic do_read;
   logic empty_pop;

   always_comb begin
      o_pop_ready  = (state == IDLE) && !o_res_valid;
      // A full queue can still take a push when the same cycle's pop frees the head slot.
      o_push_ready = (state == IDLE) &&
                     (!i_q_full || (i_pop_valid && o_pop_ready && !i_q_empty));
      push_acc     = i_push_valid && o_push_ready;
      pop_acc      = i_pop_valid && o_pop_ready;
      key_zero     = (i_push_data == '0);
      do_wrt       = push_acc && !key_zero;
      do_read      = pop_acc && !i_q_empty;
      empty_pop    = pop_acc && i_q_empty;

      state_next = state;
      case (state)
         IDLE:    if (do_wrt || do_read) state_next = CMD;
         CMD:     state_next = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         settle_cnt  <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_empty <= 1'b0;
         o_err_zero  <= 1'b0;
         o_q_wrt     <= 1'b0;
         o_q_read    <= 1'b0;
         o_q_data    <= '0;
      end else begin
         o_err_zero <= push_acc && key_zero;
         o_q_wrt    <= 1'b0;
         o_q_read   <= 1'b0;
         if (o_res_valid && i_res_ready) o_res_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (do_wrt || do_read) begin
                  o_q_wrt  <= do_wrt;
                  o_q_read <= do_read;
                  o_q_data <= i_push_data;
               end
               if (empty_pop) begin
                  o_res_valid <= 1'b1;
                  o_res_data  <= '0;
                  o_res_empty <= 1'b1;
               end
            end
            CMD: begin
               settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
               // The head is sampled while the read strobe is still up, before the queue reorders.
               if (o_q_read) begin
                  o_res_valid <= 1'b1;
                  o_res_data  <= i_q_data;
                  o_res_empty <= 1'b0;
               end
            end
            SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_register_tree_driver.sv
// Bench for register_tree_driver: emulates the queue, runs a command-selection table,
// directed cadence/corner sequences, and randomized traffic against a set-based model.
module tb_register_tree_driver;

   localparam int DW = 16;
   localparam int QS = 15;
   localparam int SC = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          empty;
   } res_t;

   typedef struct {
      bit            pv;
      logic [DW-1:0] pd;
      bit            qv;
      int            pre;
      bit            ew;
      bit            er;
      bit            ee;
      bit            eres;
      logic [DW-1:0] edata;
      bit            eempty;
   } vec_t;

   logic          i_CLK = 1'b0;
   logic          i_RST;
   logic          i_push_valid;
   logic          o_push_ready;
   logic [DW-1:0] i_push_data;
   logic          i_pop_valid;
   logic          o_pop_ready;
   logic          o_res_valid;
   logic          i_res_ready;
   logic [DW-1:0] o_res_data;
   logic          o_res_empty;
   logic          o_err_zero;
   logic          o_q_wrt;
   logic          o_q_read;
   logic [DW-1:0] o_q_data;
   logic          i_q_full;
   logic          i_q_empty;
   logic [DW-1:0] i_q_data;

   register_tree_driver #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(SC)) dut (
      .i_CLK        (i_CLK),
      .i_RST        (i_RST),
      .i_push_valid (i_push_valid),
      .o_push_ready (o_push_ready),
      .i_push_data  (i_push_data),
      .i_pop_valid  (i_pop_valid),
      .o_pop_ready  (o_pop_ready),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res_data   (o_res_data),
      .o_res_empty  (o_res_empty),
      .o_err_zero   (o_err_zero),
      .o_q_wrt      (o_q_wrt),
      .o_q_read     (o_q_read),
      .o_q_data     (o_q_data),
      .i_q_full     (i_q_full),
      .i_q_empty    (i_q_empty),
      .i_q_data     (i_q_data)
   );

   always #5 i_CLK = ~i_CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge i_CLK) cyc <= cyc + 1;

   // Strobe / result monitors, sampled mid-cycle.
   int   wrt_cnt = 0, read_cnt = 0, both_cnt = 0, err_cnt = 0;
   int   last_rise_cyc = -1;
   logic prev_rv = 1'b0;
   res_t res_log[$];

   always @(negedge i_CLK) begin
      if (o_q_wrt)              wrt_cnt++;
      if (o_q_read)             read_cnt++;
      if (o_q_wrt && o_q_read)  both_cnt++;
      if (o_err_zero)           err_cnt++;
      if (o_res_valid && !prev_rv) last_rise_cyc = cyc;
      prev_rv = o_res_valid;
      if (o_res_valid && i_res_ready && !i_RST) res_log.push_back({o_res_data, o_res_empty});
   end

   logic [DW-1:0] emu[$];
   logic          emu_w, emu_r;
   logic [DW-1:0] emu_d;
   bit            rand_on = 1'b0;

   function automatic int max_index(input logic [DW-1:0] q[$]);
      int m = 0;
      for (int k = 1; k < q.size(); k++) if (q[k] > q[m]) m = k;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic emu_drive();
      i_q_full  = (emu.size() >= QS);
      i_q_empty = (emu.size() == 0);
      i_q_data  = (emu.size() == 0) ? '0 : emu[max_index(emu)];
   endtask

   task automatic preload(input int n);
      emu.delete();
      for (int k = 0; k < n; k++) emu.push_back(DW'((k + 1) * 10));
      emu_drive();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge i_CLK);
      #1;
   endtask

   task automatic do_reset();
      i_RST = 1'b1;
      wait_cycles(2);
      i_RST = 1'b0;
   endtask

   // Holds the requested valids until the DUT is ready for all of them; returns the accept cycle.
   task automatic xfer(input bit pv, input logic [DW-1:0] pd, input bit qv, output int t_acc);
      int n = 0;
      bit done = 1'b0;
      i_push_valid = pv;
      i_push_data  = pd;
      i_pop_valid  = qv;
      t_acc = -1;
      while (!done && n < 200) begin
         @(negedge i_CLK);
         if ((!pv || o_push_ready) && (!qv || o_pop_ready)) begin
            done  = 1'b1;
            t_acc = cyc;
         end
         n++;
      end
      @(posedge i_CLK);
      #1;
      i_push_valid = 1'b0;
      i_pop_valid  = 1'b0;
      if (!done) check("handshake timeout", 32'd0, 32'd1);
   endtask

   vec_t          vecs[9];
   int            t, t2, ta[3];
   int            w0, r0, e0, b0, rl0, rl_base, exp_w, exp_r;
   logic [DW-1:0] keys[3];
   logic [DW-1:0] rq[$];
   res_t          exp_q[$];

   initial begin
      vecs = '{
         '{1, 16'd5,  0, 0,  1, 0, 0, 0, 16'd0,   0},
         '{0, 16'd0,  1, 0,  0, 0, 0, 1, 16'd0,   1},
         '{0, 16'd0,  1, 3,  0, 1, 0, 1, 16'd30,  0},
         '{1, 16'd25, 1, 3,  1, 1, 0, 1, 16'd30,  0},
         '{1, 16'd25, 1, 0,  1, 0, 0, 1, 16'd0,   1},
         '{1, 16'd0,  0, 2,  0, 0, 1, 0, 16'd0,   0},
         '{1, 16'd0,  1, 2,  0, 1, 1, 1, 16'd20,  0},
         '{1, 16'd0,  1, 0,  0, 0, 1, 1, 16'd0,   1},
         '{1, 16'd40, 1, 15, 1, 1, 0, 1, 16'd150, 0}
      };
      i_RST = 1'b1; i_push_valid = 1'b0; i_push_data = '0; i_pop_valid = 1'b0; i_res_ready = 1'b0;
      emu.delete();
      emu_drive();

      // Queue stand-in: strobes are taken at the edge, the new head appears just after it.
      fork
         forever begin
            @(posedge i_CLK);
            emu_w = o_q_wrt; emu_r = o_q_read; emu_d = o_q_data;
            #1;
            if (emu_r && emu.size() > 0) emu.delete(max_index(emu));
            if (emu_w && emu.size() < QS) emu.push_back(emu_d);
            emu_drive();
         end
      join_none

      // Reset state
      @(posedge i_CLK); #1;
      do_reset();
      @(negedge i_CLK);
      check("reset flags", {o_res_valid, o_res_empty, o_err_zero, o_q_wrt, o_q_read}, 32'd0);
      check("reset data", {o_res_data, o_q_data}, 32'd0);
      check("reset readies", {o_push_ready, o_pop_ready}, 32'd3);
      @(posedge i_CLK); #1;

      // Command-selection table, each vector from a fresh reset and preloaded queue
      for (int v = 0; v < 9; v++) begin
         i_res_ready = 1'b0;
         preload(vecs[v].pre);
         do_reset();
         w0 = wrt_cnt; r0 = read_cnt; e0 = err_cnt; b0 = both_cnt;
         xfer(vecs[v].pv, vecs[v].pd, vecs[v].qv, t);
         wait_cycles(4);
         @(negedge i_CLK);
         check($sformatf("vec%0d wrt", v), wrt_cnt - w0, vecs[v].ew);
         check($sformatf("vec%0d read", v), read_cnt - r0, vecs[v].er);
         check($sformatf("vec%0d rep", v), both_cnt - b0, vecs[v].ew & vecs[v].er);
         check($sformatf("vec%0d err", v), err_cnt - e0, vecs[v].ee);
         check($sformatf("vec%0d res_valid", v), o_res_valid, vecs[v].eres);
         if (vecs[v].eres) begin
            check($sformatf("vec%0d res_data", v), o_res_data, vecs[v].edata);
            check($sformatf("vec%0d res_empty", v), o_res_empty, vecs[v].eempty);
         end
         @(posedge i_CLK); #1;
      end

      // Push cadence: 5, 9, 3 spaced SC+2 cycles apart, one strobe each
      emu.delete(); emu_drive();
      do_reset();
      keys = '{16'd5, 16'd9, 16'd3};
      w0 = wrt_cnt;
      for (int i = 0; i < 3; i++) begin
         xfer(1'b1, keys[i], 1'b0, ta[i]);
         @(negedge i_CLK);
         check("push strobe", {o_q_wrt, o_q_read}, 32'd2);
         check("push data", o_q_data, keys[i]);
         @(posedge i_CLK); #1;
      end
      check("accept spacing 1", ta[1] - ta[0], SC + 2);
      check("accept spacing 2", ta[2] - ta[1], SC + 2);
      wait_cycles(SC + 2);
      check("push strobe count", wrt_cnt - w0, 3);

      // Three pops then an empty pop, results consumed immediately
      i_res_ready = 1'b1;
      r0 = read_cnt;
      for (int i = 0; i < 3; i++) begin
         rl0 = res_log.size();
         xfer(1'b0, '0, 1'b1, t);
         wait_cycles(3);
         if (i == 0) check("pop result latency", last_rise_cyc - t, 2);
         check("pop result count", res_log.size() - rl0, 1);
         if (res_log.size() > rl0) begin
            check("pop result data", res_log[rl0].data, (i == 0) ? 9 : (i == 1) ? 5 : 3);
            check("pop result empty", res_log[rl0].empty, 0);
         end
      end
      check("pop read count", read_cnt - r0, 3);
      r0 = read_cnt;
      xfer(1'b0, '0, 1'b1, t);
      @(negedge i_CLK);
      check("empty pop result", {o_res_valid, o_res_empty, o_res_data}, {1'b1, 1'b1, 16'd0});
      @(posedge i_CLK); #1;
      @(negedge i_CLK);
      check("empty pop no settle", {o_pop_ready, o_push_ready}, 32'd3);
      check("empty pop latency", last_rise_cyc - t, 1);
      check("empty pop no read", read_cnt - r0, 0);
      @(posedge i_CLK); #1;

      // Fill to capacity, then a replace
      for (int i = 1; i <= QS; i++) xfer(1'b1, DW'(100 + i), 1'b0, t);
      wait_cycles(SC + 2);
      i_push_valid = 1'b1; i_push_data = 16'd120;
      @(negedge i_CLK);
      check("push_ready when full", o_push_ready, 0);
      @(posedge i_CLK); #1;
      i_push_valid = 1'b0;
      w0 = wrt_cnt; r0 = read_cnt; b0 = both_cnt; rl0 = res_log.size();
      xfer(1'b1, 16'd20, 1'b1, t);
      wait_cycles(3);
      check("rep both strobes", both_cnt - b0, 1);
      check("rep single wrt", wrt_cnt - w0, 1);
      check("rep single read", read_cnt - r0, 1);
      if (res_log.size() > rl0) check("rep result", res_log[rl0].data, 115);
      else check("rep result present", 0, 1);

      // Zero-key pushes
      xfer(1'b0, '0, 1'b1, t);
      wait_cycles(SC + 2);
      w0 = wrt_cnt; r0 = read_cnt; e0 = err_cnt;
      xfer(1'b1, '0, 1'b0, t);
      @(negedge i_CLK);
      check("zero push err pulse", o_err_zero, 1);
      check("zero push ready at T+1", o_push_ready, 1);
      check("zero push no strobe", {o_q_wrt, o_q_read}, 0);
      @(posedge i_CLK); #1;
      @(negedge i_CLK);
      check("zero push err one cycle", o_err_zero, 0);
      @(posedge i_CLK); #1;
      check("zero push err count", err_cnt - e0, 1);
      rl0 = res_log.size();
      xfer(1'b1, '0, 1'b1, t);
      wait_cycles(3);
      check("zero push+pop wrt", wrt_cnt - w0, 0);
      check("zero push+pop read", read_cnt - r0, 1);
      if (res_log.size() > rl0) check("zero push+pop result", res_log[rl0].data, 113);
      else check("zero push+pop result present", 0, 1);
      wait_cycles(SC + 2);

      // Result back-pressure, push during pending result, then reset in SETTLE
      i_res_ready = 1'b0;
      xfer(1'b0, '0, 1'b1, t);
      wait_cycles(SC + 3);
      @(negedge i_CLK);
      check("pending pop_ready", o_pop_ready, 0);
      check("pending res_valid", o_res_valid, 1);
      check("pending res_data", o_res_data, 112);
      @(posedge i_CLK); #1;
      w0 = wrt_cnt;
      xfer(1'b1, 16'd7, 1'b0, t2);
      @(negedge i_CLK);
      check("pending push strobe", {o_q_wrt, o_q_data}, {1'b1, 16'd7});
      check("pending res_data stable", o_res_data, 112);
      @(posedge i_CLK); #1;
      i_RST = 1'b1;
      @(posedge i_CLK); #1;
      i_RST = 1'b0;
      @(negedge i_CLK);
      check("mid reset flags", {o_res_valid, o_res_empty, o_err_zero, o_q_wrt, o_q_read}, 0);
      check("mid reset data", {o_res_data, o_q_data}, 0);
      check("mid reset pop_ready", o_pop_ready, 1);
      check("mid reset push_ready", o_push_ready, emu.size() < QS);
      @(posedge i_CLK); #1;

      // Randomized traffic against a set-of-keys model
      emu.delete(); emu_drive();
      do_reset();
      rq.delete(); exp_q.delete();
      exp_w = 0; exp_r = 0;
      w0 = wrt_cnt; r0 = read_cnt; rl_base = res_log.size();
      rand_on = 1'b1;
      fork
         begin
            while (rand_on) begin
               @(posedge i_CLK); #1;
               i_res_ready = ($urandom_range(0, 2) != 0);
            end
            i_res_ready = 1'b1;
         end
      join_none
      for (int n = 0; n < 150; n++) begin
         int            op;
         bit            pv, qv, pok;
         logic [DW-1:0] pd;
         int            m;
         op = $urandom_range(0, 9);
         pv = (op < 5) || (op >= 8);
         qv = (op >= 5);
         if (pv && !qv && rq.size() >= QS) qv = 1'b1;
         pd = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 65535));
         pok = pv && (pd != '0);
         xfer(pv, pd, qv, t);
         if (qv) begin
            if (rq.size() == 0) exp_q.push_back({16'd0, 1'b1});
            else begin
               m = max_index(rq);
               exp_q.push_back({rq[m], 1'b0});
               rq.delete(m);
               exp_r++;
            end
         end
         if (pok) begin
            rq.push_back(pd);
            exp_w++;
         end
      end
      rand_on = 1'b0;
      wait_cycles(SC + 20);
      check("rand result count", res_log.size() - rl_base, exp_q.size());
      for (int k = 0; k < exp_q.size() && rl_base + k < res_log.size(); k++) begin
         check($sformatf("rand res %0d data", k), res_log[rl_base + k].data, exp_q[k].data);
         check($sformatf("rand res %0d empty", k), res_log[rl_base + k].empty, exp_q[k].empty);
      end
      check("rand wrt count", wrt_cnt - w0, exp_w);
      check("rand read count", read_cnt - r0, exp_r);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
